// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline stage register with a two-entry skid buffer.
// The main entry drives the outputs and the skid entry catches one bundle during
// a downstream stall, so in_ready comes only from registers.
// flush squashes the stage on the next edge. With BUBBLE_ZERO set, the control
// LSBs of out_data read zero whenever the stage shows a bubble.
module pipe_stage_reg #(
  parameter int unsigned DATA_W      = 423,
  parameter int unsigned CTRL_W      = 13,
  parameter int unsigned BUBBLE_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // The state is the occupancy: EMPTY, ONE (main live) or FULL (main and skid live).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              main_v, skid_v;
  logic              accept, drain;

  assign main_v    = (state_q != S_EMPTY);
  assign skid_v    = (state_q == S_FULL);
  assign in_ready  = !skid_v;
  assign out_valid = main_v;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  assign accept    = in_valid & in_ready;
  assign drain     = main_v & out_ready;

  // Next-state and data-path selection. A flush leaves the data registers unchanged.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            main_d = in_data;
          end else if (accept) begin
            state_d = S_FULL;
            skid_d  = in_data;
          end else if (drain) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (drain) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State and storage registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Output data. The control field is zeroed during a bubble when that behaviour is enabled.
  always_comb begin
    out_data = main_q;
    if ((BUBBLE_ZERO != 0) && !main_v) begin
      out_data[CTRL_W-1:0] = '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg. Four instances are used:
//   - default 423/13 with bubble zeroing
//   - 423/13 without bubble zeroing, driven with the same stimulus as the first
//   - 8/1 and 64/64, driven with random traffic
// A queue-level model checks every output of every instance on each falling edge.
module tb_pipe_stage_reg;

  logic clk;
  logic rst_n, flush;
  logic in_valid, out_ready;
  logic [422:0] in_data;
  logic s8_iv, s8_ordy, s64_iv, s64_ordy;
  logic [7:0] s8_id;
  logic [63:0] s64_id;

  logic d_ir, d_ov, n_ir, n_ov, s8_ir, s8_ov, s64_ir, s64_ov;
  logic [422:0] d_od, n_od;
  logic [7:0] s8_od;
  logic [63:0] s64_od;
  logic [1:0] d_occ, n_occ, s8_occ, s64_occ;

  int nchk = 0;
  int nerr = 0;
  logic chk_en;

  pipe_stage_reg #(.DATA_W(423), .CTRL_W(13), .BUBBLE_ZERO(1)) u_dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(d_ir), .in_data(in_data),
    .out_valid(d_ov), .out_ready(out_ready), .out_data(d_od), .occupancy(d_occ));

  pipe_stage_reg #(.DATA_W(423), .CTRL_W(13), .BUBBLE_ZERO(0)) u_nbz (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(n_ir), .in_data(in_data),
    .out_valid(n_ov), .out_ready(out_ready), .out_data(n_od), .occupancy(n_occ));

  pipe_stage_reg #(.DATA_W(8), .CTRL_W(1), .BUBBLE_ZERO(1)) u_s8 (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(s8_iv), .in_ready(s8_ir), .in_data(s8_id),
    .out_valid(s8_ov), .out_ready(s8_ordy), .out_data(s8_od), .occupancy(s8_occ));

  pipe_stage_reg #(.DATA_W(64), .CTRL_W(64), .BUBBLE_ZERO(1)) u_s64 (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(s64_iv), .in_ready(s64_ir), .in_data(s64_id),
    .out_valid(s64_ov), .out_ready(s64_ordy), .out_data(s64_od), .occupancy(s64_occ));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: a FIFO of at most two bundles plus the last bundle shown on
  // the output. Index 0 models the 423-bit pair, index 1 the 8-bit instance and
  // index 2 the 64-bit instance.
  logic [422:0] m_ent [3][2];
  int unsigned  m_cnt [3];
  logic [422:0] m_last [3];

  task automatic check(input string name, input logic [422:0] act, input logic [422:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int k, input logic iv, input logic [422:0] id, input logic ordy);
    logic [422:0] front;
    logic acc, drn;
    front = (m_cnt[k] > 0) ? m_ent[k][0] : m_last[k];
    acc   = iv && (m_cnt[k] < 2);
    drn   = (m_cnt[k] > 0) && ordy;
    if (flush) begin
      m_cnt[k] = 0;
    end else begin
      if (drn) begin
        m_ent[k][0] = m_ent[k][1];
        m_cnt[k]    = m_cnt[k] - 1;
      end
      if (acc) begin
        m_ent[k][m_cnt[k]] = id;
        m_cnt[k]           = m_cnt[k] + 1;
      end
    end
    m_last[k] = (m_cnt[k] > 0) ? m_ent[k][0] : front;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        m_cnt[k]    = 0;
        m_last[k]   = '0;
        m_ent[k][0] = '0;
        m_ent[k][1] = '0;
      end
    end else begin
      step(0, in_valid, in_data, out_ready);
      step(1, s8_iv, 423'(s8_id), s8_ordy);
      step(2, s64_iv, 423'(s64_id), s64_ordy);
    end
  end

  function automatic logic [422:0] exp_data(input int k, input int cw, input int dw, input bit bz);
    logic [422:0] cm, wm, v;
    cm = (423'(1) << cw) - 423'(1);
    wm = (423'(1) << dw) - 423'(1);
    if (m_cnt[k] > 0) v = m_ent[k][0];
    else v = bz ? (m_last[k] & ~cm) : m_last[k];
    return v & wm;
  endfunction

  // Compare every output of every instance against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dut_valid", 423'(d_ov), 423'(m_cnt[0] > 0));
      check("dut_ready", 423'(d_ir), 423'(m_cnt[0] < 2));
      check("dut_occ", 423'(d_occ), 423'(m_cnt[0]));
      check("dut_data", d_od, exp_data(0, 13, 423, 1'b1));
      check("nbz_valid", 423'(n_ov), 423'(m_cnt[0] > 0));
      check("nbz_ready", 423'(n_ir), 423'(m_cnt[0] < 2));
      check("nbz_occ", 423'(n_occ), 423'(m_cnt[0]));
      check("nbz_data", n_od, exp_data(0, 13, 423, 1'b0));
      check("s8_valid", 423'(s8_ov), 423'(m_cnt[1] > 0));
      check("s8_ready", 423'(s8_ir), 423'(m_cnt[1] < 2));
      check("s8_occ", 423'(s8_occ), 423'(m_cnt[1]));
      check("s8_data", 423'(s8_od), exp_data(1, 1, 8, 1'b1));
      check("s64_valid", 423'(s64_ov), 423'(m_cnt[2] > 0));
      check("s64_ready", 423'(s64_ir), 423'(m_cnt[2] < 2));
      check("s64_occ", 423'(s64_occ), 423'(m_cnt[2]));
      check("s64_data", 423'(s64_od), exp_data(2, 64, 64, 1'b1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_main(input string name, input logic ov, input logic [422:0] od,
                            input logic [1:0] occ, input logic ir);
    check({name, "_valid"}, 423'(d_ov), 423'(ov));
    check({name, "_data"}, d_od, od);
    check({name, "_occ"}, 423'(d_occ), 423'(occ));
    check({name, "_ready"}, 423'(d_ir), 423'(ir));
  endtask

  initial begin
    logic [422:0] ones, masked, va, vb, vc;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    s8_iv = 1'b0; s8_ordy = 1'b0; s8_id = '0;
    s64_iv = 1'b0; s64_ordy = 1'b0; s64_id = '0;
    chk_en = 1'b0;
    #1 rst_n = 1'b0;
    #3 chk_en = 1'b1;
    check_main("rst_init", 1'b0, '0, 2'd0, 1'b1);
    tick();
    rst_n = 1'b1;

    // Streaming: one bundle per cycle, occupancy stays at 1.
    out_ready = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      in_valid = 1'b1;
      in_data  = 423'(v);
      tick();
      check_main($sformatf("stream%0d", v), 1'b1, 423'(v), 2'd1, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    check_main("stream_empty", 1'b0, '0, 2'd0, 1'b1);

    // Stall and skid: out_ready is low for edges 2-4.
    in_valid = 1'b1; in_data = 423'(10); out_ready = 1'b1;
    tick();
    check_main("skid_e1", 1'b1, 423'(10), 2'd1, 1'b1);
    in_data = 423'(11); out_ready = 1'b0;
    tick();
    check_main("skid_e2", 1'b1, 423'(10), 2'd2, 1'b0);
    in_data = 423'(12);
    tick();
    check_main("skid_e3", 1'b1, 423'(10), 2'd2, 1'b0);
    tick();
    check_main("skid_e4", 1'b1, 423'(10), 2'd2, 1'b0);
    out_ready = 1'b1;
    tick();
    check_main("skid_e5", 1'b1, 423'(11), 2'd1, 1'b1);
    tick();
    check_main("skid_e6", 1'b1, 423'(12), 2'd1, 1'b1);
    in_data = 423'(13);
    tick();
    check_main("skid_e7", 1'b1, 423'(13), 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    check_main("skid_e8", 1'b0, '0, 2'd0, 1'b1);

    // Flush while FULL, with a third bundle offered in the same cycle.
    va = 423'h1A5A; vb = 423'h2B6B; vc = 423'h3C7C;
    out_ready = 1'b0; in_valid = 1'b1; in_data = va;
    tick();
    in_data = vb;
    tick();
    check_main("flush_full", 1'b1, va, 2'd2, 1'b0);
    in_data = vc; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush_valid", 423'(d_ov), 423'(0));
    check("flush_occ", 423'(d_occ), 423'(0));
    check("flush_ctrl", 423'(d_od[12:0]), 423'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_no_c", 423'(d_ov), 423'(0));
    end

    // Bubble masking after draining an all-ones bundle.
    ones = '1;
    masked = ones;
    masked[12:0] = '0;
    in_valid = 1'b1; in_data = ones;
    tick();
    check_main("bubble_live", 1'b1, ones, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    check("bubble_bz1", d_od, masked);
    check("bubble_bz0", n_od, ones);
    check("bubble_bz0_valid", 423'(n_ov), 423'(0));

    // Asynchronous reset while FULL, then first accept right after release.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 423'h111;
    tick();
    in_data = 423'h222;
    tick();
    check_main("pre_rst", 1'b1, 423'h111, 2'd2, 1'b0);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_main("async_rst", 1'b0, '0, 2'd0, 1'b1);
    tick();
    rst_n = 1'b1; in_valid = 1'b1; in_data = 423'h0AB; out_ready = 1'b1;
    tick();
    check_main("post_rst", 1'b1, 423'h0AB, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();

    // Random traffic on the narrow and full-control instances.
    for (int i = 0; i < 10000; i++) begin
      s8_iv    = 1'($urandom_range(0, 1));
      s8_ordy  = 1'($urandom_range(0, 1));
      s8_id    = 8'($urandom_range(0, 255));
      s64_iv   = 1'($urandom_range(0, 1));
      s64_ordy = 1'($urandom_range(0, 1));
      s64_id   = {$urandom, $urandom};
      tick();
      check("s8_occ_le2", 423'(s8_occ <= 2'd2), 423'(1));
      check("s64_occ_le2", 423'(s64_occ <= 2'd2), 423'(1));
    end
    s8_iv = 1'b0; s64_iv = 1'b0; s8_ordy = 1'b1; s64_ordy = 1'b1;
    tick();
    tick();
    tick();
    check("s8_drained", 423'(s8_occ), 423'(0));
    check("s64_drained", 423'(s64_occ), 423'(0));

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline stage register that replaces fixed-width, always-load stage registers between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width bundle of control and data fields with a valid/ready handshake. A two-entry skid buffer gives full throughput with no combinational ready path. Synchronous flush and bubble-zeroing of control fields support hazard stalls and branch squashes.

## Interface
Parameters:
- DATA_W, 423, total width of the packed stage bundle
- CTRL_W, 13, number of LSBs of the bundle that are control bits (RegWrite, memWrite, branch, ...); must be ≤ DATA_W
- BUBBLE_ZERO, 1, when 1, control bits on out_data read 0 whenever out_valid=0

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- flush  input  1  synchronous squash; empties the stage on the next edge
- in_valid  input  1  upstream presents a bundle
- in_ready  output  1  stage can accept a bundle this cycle
- in_data  input  DATA_W  upstream bundle; control field is in_data[CTRL_W-1:0]
- out_valid  output  1  out_data holds a live bundle
- out_ready  input  1  downstream accepts this cycle; 0 means stall
- out_data  output  DATA_W  bundle presented to the next stage
- occupancy  output  2  entries held: 0, 1 or 2

## Operation
- Storage: main entry (main_data, main_v) drives the outputs. Skid entry (skid_data, skid_v) absorbs one bundle when downstream stalls.
- State is encoded by occupancy:
  - EMPTY: main_v=0, skid_v=0
  - ONE: main_v=1, skid_v=0
  - FULL: main_v=1, skid_v=1
- in_ready = (state != FULL). It is decoded from registers only and never depends on out_ready or in_valid.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Transitions when flush=0:
  - EMPTY, accept → ONE, main ← in_data
  - EMPTY, no accept → EMPTY
  - ONE, accept & drain → ONE, main ← in_data
  - ONE, accept & !drain → FULL, skid ← in_data, main held
  - ONE, !accept & drain → EMPTY
  - ONE, neither → ONE, hold
  - FULL, drain → ONE, main ← skid, skid_v ← 0
  - FULL, !drain → FULL, hold
- flush=1: next state EMPTY regardless of accept or drain. A bundle offered in the flush cycle is discarded, even though in_ready may read 1. A drain in the flush cycle still counts downstream: the bundle was presented and taken.
- out_valid = main_v.
- out_data = main_data, except that when BUBBLE_ZERO=1 and main_v=0, bits [CTRL_W-1:0] read 0. Upper bits always show main_data.
- Order is strictly FIFO. There is no loss and no duplication outside flush.
- occupancy = main_v + skid_v.

## Timing
- Reset (reset=0, asynchronous): main_v=skid_v=0, main_data=skid_data=0, so out_valid=0, out_data=0, occupancy=0, in_ready=1. Outputs change without waiting for a clock edge.
- Reset deassertion is sampled on the next rising edge. The first accept can occur on that edge.
- Reset asserted mid-operation (any state) returns to EMPTY at once, and all stored bundles are lost.
- Latency: a bundle accepted on edge N appears on out_data/out_valid after edge N, i.e. one cycle.
- Throughput: one bundle per cycle while out_ready=1.
- A single out_ready low cycle costs no upstream bubble: the skid entry absorbs it, and in_ready drops one cycle later.
- A continuous stall fills the stage in at most 2 accepts. in_ready=0 from the edge the state enters FULL.
- FULL with out_ready=1: in_ready is still 0 in that cycle. It returns to 1 after the edge.
- Stall then release sequence: ONE → FULL → ONE → ONE. There are no dead cycles while in_valid stays high.
- flush and reset together: reset wins.
- All outputs are registered or decoded only from registers. There is no in→out combinational path.

## Test plan
- Reset: drive reset=0 mid-cycle with occupancy=2. Required: out_valid=0, out_data=0, occupancy=0, in_ready=1 immediately. After release, in_data=0x…0AB with in_valid=1 gives out_valid=1 and out_data=0x…0AB one edge later.
- Streaming: in_valid=1 with in_data=1,2,3,4,5 on consecutive edges and out_ready=1. Required: out_data=1..5 on edges 1..5, occupancy stays 1, in_ready stays 1.
- Stall/skid: stream 10,11,12,13 and hold out_ready=0 for edges 2-4. Required:
  - occupancy reaches 2 and in_ready=0 after 11 is accepted, with 10 held on the output
  - 12 waits upstream while in_ready=0 and is not accepted
  - on release, output order is 10,11,12,13 with no drop and no duplicate
- Flush: FULL holding A,B with in_valid=1 (C) and flush=1 for one edge. Required: the next cycle has out_valid=0, occupancy=0, and C is never output. With BUBBLE_ZERO=1, out_data[12:0]=0.
- Bubble masking: with DATA_W=423, CTRL_W=13, empty stage after a drain of 0x7FFF…FFFF. Required: out_data[12:0]=0 and out_data[422:13] unchanged. Repeat with BUBBLE_ZERO=0: all bits unchanged.
- Parameter sweep: DATA_W=8, CTRL_W=1 and DATA_W=64, CTRL_W=64, with random in_valid/out_ready over 10k cycles against a FIFO scoreboard. Required: no loss, no reorder, and occupancy never exceeds 2.
